alu_arbiter: RTL and testbench

- Shares the single 8-bit combinational ALU between two requesters: port A (core datapath) and port B (auxiliary unit, e.g. loop/address helper).
- Accepts one operation at a time, registers opcode and operands onto the ALU inputs, then captures the ALU result and jump flag into a per-requester response register.
- Handshake is valid/ready on both request and response channels. Arbitration is round-robin, or optionally fixed priority.
- Sits between the requesters and the ALU; the ALU itself is unchanged.

---
 rtl/alu_arbiter.sv | 139 +++++++++++++
 tb/tb_alu_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between requesters A and B.
// Each accepted op takes two cycles: operands are registered onto the ALU, then the result is captured per requester.
module alu_arbiter #(
    parameter int WIDTH      = 8,
    parameter int OPW        = 3,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic             clk,
    input  logic             reset_n,

    input  logic             aReqValid,
    output logic             aReqReady,
    input  logic [OPW-1:0]   aReqOp,
    input  logic [WIDTH-1:0] aReqIn1,
    input  logic [WIDTH-1:0] aReqIn2,
    output logic             aRspValid,
    input  logic             aRspReady,
    output logic [WIDTH-1:0] aRspData,
    output logic             aRspJump,

    input  logic             bReqValid,
    output logic             bReqReady,
    input  logic [OPW-1:0]   bReqOp,
    input  logic [WIDTH-1:0] bReqIn1,
    input  logic [WIDTH-1:0] bReqIn2,
    output logic             bRspValid,
    input  logic             bRspReady,
    output logic [WIDTH-1:0] bRspData,
    output logic             bRspJump,

    output logic [OPW-1:0]   aluOp,
    output logic [WIDTH-1:0] aluIn1,
    output logic [WIDTH-1:0] aluIn2,
    input  logic [WIDTH-1:0] aluOut,
    input  logic             aluJump,

    output logic             busy
);

    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_t;

    state_t state;
    state_t nextState;

    // Requester encoding for lastGrant and grantee: 0 = A, 1 = B.
    logic lastGrant;
    logic grantee;
    logic aEligible;
    logic bEligible;
    logic pickB;
    logic accept;
    logic capture;

    // A held, unconsumed response blocks only its own requester.
    assign aEligible = aReqValid && (!aRspValid || aRspReady);
    assign bEligible = bReqValid && (!bRspValid || bRspReady);
    assign pickB     = bEligible && (!aEligible || (!FIXED_PRIO && !lastGrant));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Ready is withheld while reset is asserted so nothing looks accepted during reset.
    always_comb begin
        nextState = state;
        aReqReady = 1'b0;
        bReqReady = 1'b0;
        busy      = 1'b0;
        accept    = 1'b0;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if ((aEligible || bEligible) && reset_n) begin
                    accept    = 1'b1;
                    aReqReady = !pickB;
                    bReqReady = pickB;
                    nextState = EXEC;
                end
            end
            EXEC: begin
                busy      = 1'b1;
                capture   = 1'b1;
                nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            aluOp     <= '0;
            aluIn1    <= '0;
            aluIn2    <= '0;
            grantee   <= 1'b0;
            lastGrant <= 1'b1;
        end else if (accept) begin
            aluOp     <= pickB ? bReqOp  : aReqOp;
            aluIn1    <= pickB ? bReqIn1 : aReqIn1;
            aluIn2    <= pickB ? bReqIn2 : aReqIn2;
            grantee   <= pickB;
            lastGrant <= pickB;
        end
    end

    // A fresh capture wins over consumption on the same edge, keeping valid high.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            aRspValid <= 1'b0;
            aRspData  <= '0;
            aRspJump  <= 1'b0;
            bRspValid <= 1'b0;
            bRspData  <= '0;
            bRspJump  <= 1'b0;
        end else begin
            if (capture && !grantee) begin
                aRspValid <= 1'b1;
                aRspData  <= aluOut;
                aRspJump  <= aluJump;
            end else if (aRspValid && aRspReady) begin
                aRspValid <= 1'b0;
            end
            if (capture && grantee) begin
                bRspValid <= 1'b1;
                bRspData  <= aluOut;
                bRspJump  <= aluJump;
            end else if (bRspValid && bRspReady) begin
                bRspValid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a round-robin and a fixed-priority instance share
// the same request stimulus, each driving its own small ALU model.
module tb_alu_arbiter;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_AND  = 3'd2;
    localparam logic [2:0] OP_OR   = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;
    localparam logic [2:0] OP_BLQZ = 3'd5;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       aReqValid, bReqValid, aRspReady, bRspReady;
    logic [2:0] aReqOp, bReqOp;
    logic [7:0] aReqIn1, aReqIn2, bReqIn1, bReqIn2;

    logic       rAReqReady, rARspValid, rARspJump, rBReqReady, rBRspValid, rBRspJump, rAluJump, rBusy;
    logic [7:0] rARspData, rBRspData, rAluIn1, rAluIn2, rAluOut;
    logic [2:0] rAluOp;
    logic       fAReqReady, fARspValid, fARspJump, fBReqReady, fBRspValid, fBRspJump, fAluJump, fBusy;
    logic [7:0] fARspData, fBRspData, fAluIn1, fAluIn2, fAluOut;
    logic [2:0] fAluOp;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    // Reference ALU: BLQZ jumps when In1 - In2 is negative (signed).
    function automatic logic [8:0] aluModel(input logic [2:0] op, input logic [7:0] x, input logic [7:0] y);
        logic [7:0] diff;
        diff = x - y;
        case (op)
            OP_ADD:  aluModel = {1'b0, x + y};
            OP_SUB:  aluModel = {1'b0, diff};
            OP_AND:  aluModel = {1'b0, x & y};
            OP_OR:   aluModel = {1'b0, x | y};
            OP_XOR:  aluModel = {1'b0, x ^ y};
            OP_BLQZ: aluModel = {diff[7], diff};
            default: aluModel = 9'd0;
        endcase
    endfunction

    always_comb {rAluJump, rAluOut} = aluModel(rAluOp, rAluIn1, rAluIn2);
    always_comb {fAluJump, fAluOut} = aluModel(fAluOp, fAluIn1, fAluIn2);

    alu_arbiter #(.WIDTH(8), .OPW(3), .FIXED_PRIO(1'b0)) dutRr (
        .clk(clk), .reset_n(reset_n),
        .aReqValid(aReqValid), .aReqReady(rAReqReady), .aReqOp(aReqOp), .aReqIn1(aReqIn1), .aReqIn2(aReqIn2),
        .aRspValid(rARspValid), .aRspReady(aRspReady), .aRspData(rARspData), .aRspJump(rARspJump),
        .bReqValid(bReqValid), .bReqReady(rBReqReady), .bReqOp(bReqOp), .bReqIn1(bReqIn1), .bReqIn2(bReqIn2),
        .bRspValid(rBRspValid), .bRspReady(bRspReady), .bRspData(rBRspData), .bRspJump(rBRspJump),
        .aluOp(rAluOp), .aluIn1(rAluIn1), .aluIn2(rAluIn2), .aluOut(rAluOut), .aluJump(rAluJump),
        .busy(rBusy)
    );

    alu_arbiter #(.WIDTH(8), .OPW(3), .FIXED_PRIO(1'b1)) dutFp (
        .clk(clk), .reset_n(reset_n),
        .aReqValid(aReqValid), .aReqReady(fAReqReady), .aReqOp(aReqOp), .aReqIn1(aReqIn1), .aReqIn2(aReqIn2),
        .aRspValid(fARspValid), .aRspReady(aRspReady), .aRspData(fARspData), .aRspJump(fARspJump),
        .bReqValid(bReqValid), .bReqReady(fBReqReady), .bReqOp(bReqOp), .bReqIn1(bReqIn1), .bReqIn2(bReqIn2),
        .bRspValid(fBRspValid), .bRspReady(bRspReady), .bRspData(fBRspData), .bRspJump(fBRspJump),
        .aluOp(fAluOp), .aluIn1(fAluIn1), .aluIn2(fAluIn2), .aluOut(fAluOut), .aluJump(fAluJump),
        .busy(fBusy)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic av, input logic [2:0] aop, input logic [7:0] a1, input logic [7:0] a2,
                                 input logic bv, input logic [2:0] bop, input logic [7:0] b1, input logic [7:0] b2);
        aReqValid = av; aReqOp = aop; aReqIn1 = a1; aReqIn2 = a2;
        bReqValid = bv; bReqOp = bop; bReqIn1 = b1; bReqIn2 = b2;
    endtask

    task automatic nextEdge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        applyStimulus(1'b0, OP_ADD, 8'h00, 8'h00, 1'b0, OP_ADD, 8'h00, 8'h00);
        aRspReady = 1'b0;
        bRspReady = 1'b0;

        // Reset state
        @(negedge clk);
        checkOutput("rst_busy", 32'(rBusy), 0);
        checkOutput("rst_aluOp", 32'(rAluOp), 0);
        checkOutput("rst_aluIn1", 32'(rAluIn1), 0);
        checkOutput("rst_aluIn2", 32'(rAluIn2), 0);
        checkOutput("rst_aRspValid", 32'(rARspValid), 0);
        checkOutput("rst_bRspValid", 32'(rBRspValid), 0);
        checkOutput("rst_aRspData", 32'(rARspData), 0);
        nextEdge();
        reset_n = 1'b1;

        // Single A op: ADD 12 + 05
        applyStimulus(1'b1, OP_ADD, 8'h12, 8'h05, 1'b0, OP_ADD, 8'h00, 8'h00);
        @(negedge clk);
        checkOutput("single_aReady", 32'(rAReqReady), 1);
        checkOutput("single_bReady", 32'(rBReqReady), 0);
        nextEdge();
        applyStimulus(1'b0, OP_ADD, 8'h00, 8'h00, 1'b0, OP_ADD, 8'h00, 8'h00);
        @(negedge clk);
        checkOutput("single_aluIn1", 32'(rAluIn1), 'h12);
        checkOutput("single_aluIn2", 32'(rAluIn2), 'h05);
        checkOutput("single_aluOp", 32'(rAluOp), 32'(OP_ADD));
        checkOutput("single_busy", 32'(rBusy), 1);
        checkOutput("single_exec_aReady", 32'(rAReqReady), 0);
        nextEdge();
        @(negedge clk);
        checkOutput("single_aRspValid", 32'(rARspValid), 1);
        checkOutput("single_aRspData", 32'(rARspData), 'h17);
        checkOutput("single_aRspJump", 32'(rARspJump), 0);
        checkOutput("single_bRspValid", 32'(rBRspValid), 0);
        checkOutput("single_idle_busy", 32'(rBusy), 0);
        nextEdge();
        aRspReady = 1'b1;
        nextEdge();
        @(negedge clk);
        checkOutput("single_consumed", 32'(rARspValid), 0);

        // Tie after a fresh reset: A first, then RR alternates while FP keeps A
        reset_n = 1'b0;
        nextEdge();
        reset_n = 1'b1;
        aRspReady = 1'b1;
        bRspReady = 1'b1;
        applyStimulus(1'b1, OP_XOR, 8'hFF, 8'h0F, 1'b1, OP_AND, 8'hF0, 8'h3C);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput($sformatf("tie_rr_aReady_%0d", i), 32'(rAReqReady), 32'(i % 2 == 0));
            checkOutput($sformatf("tie_rr_bReady_%0d", i), 32'(rBReqReady), 32'(i % 2 == 1));
            checkOutput($sformatf("tie_fp_aReady_%0d", i), 32'(fAReqReady), 1);
            checkOutput($sformatf("tie_fp_bReady_%0d", i), 32'(fBReqReady), 0);
            if (i % 2 == 1) begin
                checkOutput($sformatf("tie_rr_aRspValid_%0d", i), 32'(rARspValid), 1);
                checkOutput($sformatf("tie_rr_aRspData_%0d", i), 32'(rARspData), 'hF0);
            end else if (i > 0) begin
                checkOutput($sformatf("tie_rr_bRspValid_%0d", i), 32'(rBRspValid), 1);
                checkOutput($sformatf("tie_rr_bRspData_%0d", i), 32'(rBRspData), 'h30);
            end
            nextEdge();
            @(negedge clk);
            checkOutput($sformatf("tie_rr_busy_%0d", i), 32'(rBusy), 1);
            checkOutput($sformatf("tie_exec_bReady_%0d", i), 32'(rBReqReady), 0);
            nextEdge();
        end
        applyStimulus(1'b0, OP_XOR, 8'hFF, 8'h0F, 1'b1, OP_AND, 8'hF0, 8'h3C);
        @(negedge clk);
        checkOutput("tie_fp_aRspData", 32'(fARspData), 'hF0);
        checkOutput("tie_fp_bRspValid", 32'(fBRspValid), 0);
        checkOutput("tie_fp_bReady_after_drop", 32'(fBReqReady), 1);
        checkOutput("tie_fp_aReady_after_drop", 32'(fAReqReady), 0);
        checkOutput("tie_rr_bReady_after_drop", 32'(rBReqReady), 1);
        nextEdge();
        applyStimulus(1'b0, OP_ADD, 8'h00, 8'h00, 1'b0, OP_ADD, 8'h00, 8'h00);
        nextEdge();
        nextEdge();

        // Response backpressure on A
        aRspReady = 1'b0;
        applyStimulus(1'b1, OP_ADD, 8'h12, 8'h05, 1'b0, OP_ADD, 8'h00, 8'h00);
        nextEdge();
        applyStimulus(1'b1, OP_OR, 8'h0F, 8'h30, 1'b1, OP_SUB, 8'h20, 8'h01);
        nextEdge();
        @(negedge clk);
        checkOutput("bp_aReady_blocked", 32'(rAReqReady), 0);
        checkOutput("bp_bReady", 32'(rBReqReady), 1);
        checkOutput("bp_aRspValid", 32'(rARspValid), 1);
        checkOutput("bp_aRspData", 32'(rARspData), 'h17);
        nextEdge();
        @(negedge clk);
        checkOutput("bp_aRspData_hold", 32'(rARspData), 'h17);
        checkOutput("bp_aRspValid_hold", 32'(rARspValid), 1);
        checkOutput("bp_aluIn1_b", 32'(rAluIn1), 'h20);
        nextEdge();
        applyStimulus(1'b1, OP_OR, 8'h0F, 8'h30, 1'b0, OP_ADD, 8'h00, 8'h00);
        aRspReady = 1'b1;
        @(negedge clk);
        checkOutput("bp_aReady_release", 32'(rAReqReady), 1);
        checkOutput("bp_bRspValid", 32'(rBRspValid), 1);
        checkOutput("bp_bRspData", 32'(rBRspData), 'h1F);
        nextEdge();
        applyStimulus(1'b0, OP_ADD, 8'h00, 8'h00, 1'b0, OP_ADD, 8'h00, 8'h00);
        @(negedge clk);
        checkOutput("bp_aRspValid_cleared", 32'(rARspValid), 0);
        checkOutput("bp_aluIn1_a", 32'(rAluIn1), 'h0F);
        checkOutput("bp_aluOp_a", 32'(rAluOp), 32'(OP_OR));
        nextEdge();
        @(negedge clk);
        checkOutput("bp_aRspData_new", 32'(rARspData), 'h3F);
        checkOutput("bp_aRspValid_new", 32'(rARspValid), 1);
        nextEdge();

        // Jump pass-through on B: 3 - 7 < 0 jumps, 9 - 7 does not
        applyStimulus(1'b0, OP_ADD, 8'h00, 8'h00, 1'b1, OP_BLQZ, 8'h03, 8'h07);
        nextEdge();
        applyStimulus(1'b0, OP_ADD, 8'h00, 8'h00, 1'b1, OP_BLQZ, 8'h09, 8'h07);
        nextEdge();
        @(negedge clk);
        checkOutput("jump_taken", 32'(rBRspJump), 1);
        checkOutput("jump_taken_data", 32'(rBRspData), 'hFC);
        nextEdge();
        applyStimulus(1'b0, OP_ADD, 8'h00, 8'h00, 1'b0, OP_ADD, 8'h00, 8'h00);
        nextEdge();
        @(negedge clk);
        checkOutput("jump_not_taken", 32'(rBRspJump), 0);
        checkOutput("jump_not_taken_data", 32'(rBRspData), 'h02);
        nextEdge();

        // Reset in the middle of EXEC
        applyStimulus(1'b1, OP_ADD, 8'h12, 8'h05, 1'b1, OP_SUB, 8'h20, 8'h01);
        nextEdge();
        reset_n = 1'b0;
        @(negedge clk);
        checkOutput("midrst_busy", 32'(rBusy), 0);
        checkOutput("midrst_aluIn1", 32'(rAluIn1), 0);
        checkOutput("midrst_aluOp", 32'(rAluOp), 0);
        checkOutput("midrst_aReady", 32'(rAReqReady), 0);
        checkOutput("midrst_bReady", 32'(rBReqReady), 0);
        checkOutput("midrst_aRspValid", 32'(rARspValid), 0);
        nextEdge();
        reset_n = 1'b1;
        @(negedge clk);
        checkOutput("postrst_aRspValid", 32'(rARspValid), 0);
        checkOutput("postrst_bRspValid", 32'(rBRspValid), 0);
        checkOutput("postrst_aReady", 32'(rAReqReady), 1);
        checkOutput("postrst_bReady", 32'(rBReqReady), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
